alu_seq_ctrl: RTL and testbench

- Two-requester sequencer for the shared 16-bit registered ALU (opcodes 0000–1111; 16-bit result on d, 32-bit result on e for 11xx).
- Arbitrates round-robin between requesters and drives the ALU operand and select lines.
- Waits out the ALU pipeline latency, selects the correct result field, and returns it with a requester ID over a valid/ready response channel.
- One operation outstanding at a time.

---
 rtl/alu_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Two-requester round-robin sequencer for a shared registered ALU.
// Issues one operation at a time, waits out the ALU latency and returns the result.
module alu_seq_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic [15:0]      req0_c,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic [15:0]      req1_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_wide,
  output logic [31:0]      rsp_data,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [15:0]      alu_c,
  output logic [3:0]       alu_s,
  input  logic [15:0]      alu_d,
  input  logic [31:0]      alu_e,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int WC_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state, state_nxt;
  logic              rr_ptr;
  logic [WC_W-1:0]   wait_cnt;
  logic              gnt_any;
  logic              gnt_id;
  logic              accept;
  logic              capture;
  logic              complete;

  // Contention resolves to rr_ptr; a lone valid wins outright.
  always_comb begin
    gnt_any    = req0_valid | req1_valid;
    gnt_id     = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    accept     = (state == IDLE) && gnt_any;
    capture    = (state == WAIT) && (wait_cnt == '0);
    complete   = (state == RESP) && rsp_ready;
    req0_ready = accept && !gnt_id;
    req1_ready = accept && gnt_id;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)   state_nxt = WAIT;
      WAIT:    if (capture)  state_nxt = RESP;
      RESP:    if (complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= 1'b0;
      wait_cnt <= '0;
      done_cnt <= '0;
      rsp_id   <= 1'b0;
      rsp_wide <= 1'b0;
      rsp_data <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_c    <= '0;
      alu_s    <= '0;
    end else begin
      if (accept) begin
        alu_s    <= gnt_id ? req1_op : req0_op;
        alu_a    <= gnt_id ? req1_a  : req0_a;
        alu_b    <= gnt_id ? req1_b  : req0_b;
        alu_c    <= gnt_id ? req1_c  : req0_c;
        rsp_id   <= gnt_id;
        wait_cnt <= WC_W'(ALU_LAT);
      end
      if (state == WAIT) begin
        if (capture) begin
          // Only the field the opcode class writes is valid; the other may be stale.
          rsp_wide <= (alu_s[3:2] == 2'b11);
          rsp_data <= (alu_s[3:2] == 2'b11) ? alu_e : {16'h0000, alu_d};
        end else begin
          wait_cnt <= wait_cnt - 1'b1;
        end
      end
      if (complete) begin
        done_cnt <= done_cnt + 1'b1;
        rr_ptr   <= ~rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a one-stage behavioural ALU.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_op;
  logic [15:0] req0_a, req0_b, req0_c;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_op;
  logic [15:0] req1_a, req1_b, req1_c;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_wide;
  logic [31:0] rsp_data;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_s;
  logic [15:0] alu_d;
  logic [31:0] alu_e;
  logic        busy;
  logic [3:0]  done_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [3:0]  exp_cnt;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.ALU_LAT(1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_wide(rsp_wide), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_s(alu_s),
    .alu_d(alu_d), .alu_e(alu_e), .busy(busy), .done_cnt(done_cnt)
  );

  // Behavioural ALU: narrow ops write d only, 11xx ops write e only.
  always @(posedge clk) begin
    case (alu_s)
      4'b0000: alu_d <= alu_a & alu_b;
      4'b0001: alu_d <= alu_a | alu_b;
      4'b0010: alu_d <= alu_a ^ alu_b;
      4'b0011: alu_d <= ~alu_a;
      4'b0100: alu_d <= alu_a - alu_b;
      4'b0101: alu_d <= alu_a << 1;
      4'b0110: alu_d <= alu_a >> 1;
      4'b0111: alu_d <= alu_a + alu_b;
      4'b1000: alu_d <= alu_a + alu_b + alu_c;
      4'b1001: alu_d <= alu_a | alu_b | alu_c;
      4'b1010: alu_d <= alu_a & alu_b & alu_c;
      4'b1011: alu_d <= alu_a ^ alu_b ^ alu_c;
      4'b1100: alu_e <= 32'(alu_a) * 32'(alu_b);
      4'b1101: alu_e <= 32'(alu_a) * 32'(alu_b) + 32'(alu_c);
      4'b1110: alu_e <= 32'(alu_a) * 32'(alu_b);
      default: alu_e <= {alu_a, alu_b};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept_op(input logic id, input logic [3:0] op,
                           input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_c = c; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_c = c; req0_valid = 1'b1;
    end
    #1;
    check("ready_granted", id ? req1_ready : req0_ready, 1);
    check("ready_other", id ? req0_ready : req1_ready, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!rsp_valid && n < 10);
    check("rsp_latency", n, 3);
  endtask

  task automatic run_op(input logic id, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [31:0] exp_data, input logic exp_wide);
    accept_op(id, op, a, b, c);
    wait_rsp();
    check("rsp_data", rsp_data, exp_data);
    check("rsp_wide", rsp_wide, exp_wide);
    check("rsp_id", rsp_id, id);
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 1'b1;
    check("done_cnt", done_cnt, exp_cnt);
    check("rsp_valid_drop", rsp_valid, 0);
  endtask

  initial begin
    int cyc, accepts, resp_idx, n;
    logic both_hi, seen;
    int gid[4];
    int gcyc[4];

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_c = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_c = '0;
    rsp_ready = 1'b1;
    exp_cnt = '0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done_cnt", done_cnt, 0);
    check("reset_alu_s", alu_s, 0);
    check("reset_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic narrow op, then a wide op, then a narrow op with stale e.
    run_op(1'b0, 4'b0000, 16'h00FF, 16'h0F0F, 16'h0000, 32'h0000000F, 1'b0);
    run_op(1'b1, 4'b1110, 16'h0100, 16'h0200, 16'h0000, 32'h00020000, 1'b1);
    run_op(1'b1, 4'b0111, 16'hFFFF, 16'h0001, 16'h0000, 32'h00000000, 1'b0);

    // Both requesters continuously valid.
    @(negedge clk);
    req0_op = 4'b1001; req0_a = '0; req0_b = 16'h1234; req0_c = 16'h0008;
    req1_op = 4'b1001; req1_a = '0; req1_b = 16'h1234; req1_c = 16'h0008;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cyc = 0; accepts = 0; resp_idx = 0; both_hi = 1'b0;
    while (accepts < 4 && cyc < 60) begin
      if (cyc > 0) @(negedge clk);
      #1;
      cyc++;
      if (req0_ready && req1_ready) both_hi = 1'b1;
      if (rsp_valid) begin
        check("rr_rsp_data", rsp_data, 32'h0000123C);
        check("rr_rsp_id", rsp_id, gid[resp_idx]);
        resp_idx++;
      end
      if (req0_ready || req1_ready) begin
        gid[accepts] = int'(req1_ready);
        gcyc[accepts] = cyc;
        accepts++;
        if (accepts == 4) begin
          @(posedge clk);
          #1;
          req0_valid = 1'b0; req1_valid = 1'b0;
        end
      end
    end
    check("rr_accepts", accepts, 4);
    check("rr_grant0", gid[0], 0);
    check("rr_grant1", gid[1], 1);
    check("rr_grant2", gid[2], 0);
    check("rr_grant3", gid[3], 1);
    check("rr_spacing1", gcyc[1] - gcyc[0], 4);
    check("rr_spacing3", gcyc[3] - gcyc[2], 4);
    check("rr_both_ready", both_hi, 0);
    wait_rsp();
    check("rr_last_id", rsp_id, 1);
    check("rr_last_wide", rsp_wide, 0);
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 4'd4;
    check("rr_done_cnt", done_cnt, exp_cnt);

    // Backpressure in RESP.
    rsp_ready = 1'b0;
    accept_op(1'b0, 4'b0010, 16'h00FF, 16'h0F0F, 16'h0000);
    wait_rsp();
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, 32'h00000FF0);
      check("hold_req0_ready", req0_ready, 0);
      check("hold_req1_ready", req1_ready, 0);
      check("hold_busy", busy, 1);
      check("hold_done_cnt", done_cnt, exp_cnt);
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 1'b1;
    check("hold_release_valid", rsp_valid, 0);
    check("hold_release_cnt", done_cnt, exp_cnt);
    repeat (2) @(negedge clk);
    #1;
    check("idle_ready_no_effect", done_cnt, exp_cnt);

    // Reset asserted while waiting on the ALU.
    accept_op(1'b1, 4'b1101, 16'h0003, 16'h0003, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_wide", rsp_wide, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_s", alu_s, 0);
    check("rst_busy", busy, 0);
    check("rst_done_cnt", done_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("rst_no_rsp", seen, 0);

    // Contention right after reset must favour requester 0.
    @(negedge clk);
    req0_op = 4'b0000; req0_a = 16'h0005; req0_b = 16'hFFFF; req0_c = '0;
    req1_op = 4'b0000; req1_a = 16'h0009; req1_b = 16'hFFFF; req1_c = '0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("post_rst_req0_ready", req0_ready, 1);
    check("post_rst_req1_ready", req1_ready, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp();
    check("post_rst_id", rsp_id, 0);
    check("post_rst_data", rsp_data, 32'h00000005);
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 1'b1;
    check("post_rst_cnt", done_cnt, exp_cnt);

    // 15 more completions wrap the 4-bit counter to 0.
    for (int i = 1; i < 16; i++) begin
      if (i % 2 == 1)
        run_op(1'b1, 4'b1100, 16'(i), 16'h0002, 16'h0000, 32'(2 * i), 1'b1);
      else
        run_op(1'b0, 4'b0000, 16'(i), 16'hFFFF, 16'h0000, 32'(i), 1'b0);
    end
    check("wrap_done_cnt", done_cnt, 0);

    n = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
